// File: rtl/gpio_pad_pkg.sv
// Shared types and default parameters for the GPIO pad controller.
package gpio_pad_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Debounce FSM states
  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } dbnc_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Parameterized flop-chain synchronizer for an asynchronous single-bit input.
module gpio_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the chain, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: registered A/DIR drive, synchronized (optionally
// debounced) Y readback, edge strobes with turnaround blanking, sticky irq.
// Build option: define GPIO_PAD_DEBOUNCE_EN to compile in the debounce FSM.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic out_data,
  input  logic dir,
  input  logic rise_en,
  input  logic fall_en,
  input  logic irq_clr,
  output logic pad_a,
  output logic pad_dir,
  input  logic pad_y,
  output logic in_data,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic irq
);

`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int DBNC_LOAD = DEBOUNCE_CYCLES;
`else
  localparam int DBNC_LOAD = 0;
`endif
  localparam int BLANK_LOAD = SYNC_STAGES + DBNC_LOAD;
  localparam int BLANK_W    = $clog2(BLANK_LOAD + 1);

  logic               pad_a_r;
  logic               pad_dir_r;
  logic               sync_y_s;
  logic               in_data_r;
  logic               in_data_s;
  logic [BLANK_W-1:0] blank_cnt_r;
  logic               edge_ok_s;
  logic               rise_pulse_r;
  logic               fall_pulse_r;
  logic               irq_r;

  gpio_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_y),
    .q   (sync_y_s)
  );

  // Registered drive of the pad-cell A and DIR pins; reset parks the pad as input
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_a_r   <= 1'b0;
      pad_dir_r <= 1'b1;
    end else begin
      pad_a_r   <= out_data;
      pad_dir_r <= dir;
    end
  end

`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  dbnc_state_e      state_r;
  dbnc_state_e      state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  // Debounce next-state: cnt holds the length of the current differing run,
  // and the run commits on the sample that brings it to DEBOUNCE_CYCLES
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    in_data_s = in_data_r;
    case (state_r)
      ST_STABLE: begin
        if (sync_y_s != in_data_r) begin
          if (CNT_COMMIT == CNT_W'(0)) begin
            in_data_s = sync_y_s;
            cnt_s     = CNT_W'(0);
          end else begin
            state_s = ST_COUNT;
            cnt_s   = CNT_W'(1);
          end
        end else begin
          cnt_s = CNT_W'(0);
        end
      end
      ST_COUNT: begin
        if (sync_y_s == in_data_r) begin
          state_s = ST_STABLE;
          cnt_s   = CNT_W'(0);
        end else if (cnt_r >= CNT_COMMIT) begin
          in_data_s = sync_y_s;
          state_s   = ST_STABLE;
          cnt_s     = CNT_W'(0);
        end else if (cnt_r < CNT_MAX) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_STABLE;
        cnt_s   = CNT_W'(0);
      end
    endcase
  end

  // Debounce state register; dir is deliberately not an input here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_STABLE;
      cnt_r   <= CNT_W'(0);
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end
`else
  // Without debounce the synchronized value is taken directly
  always_comb begin
    in_data_s = sync_y_s;
  end
`endif

  // Readback register
  always_ff @(posedge clk) begin
    if (rst) begin
      in_data_r <= 1'b0;
    end else begin
      in_data_r <= in_data_s;
    end
  end

  // Blanking window after the pad turns around from output to input
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt_r <= BLANK_W'(0);
    end else if (!pad_dir_r && dir) begin
      blank_cnt_r <= BLANK_W'(BLANK_LOAD);
    end else if (blank_cnt_r != BLANK_W'(0)) begin
      blank_cnt_r <= blank_cnt_r - BLANK_W'(1);
    end else begin
      blank_cnt_r <= blank_cnt_r;
    end
  end

  // Edges are reported only in input mode and outside the blanking window
  always_comb begin
    edge_ok_s = pad_dir_r && (blank_cnt_r == BLANK_W'(0));
  end

  // Edge strobes registered in the same edge that updates in_data
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_pulse_r <= 1'b0;
      fall_pulse_r <= 1'b0;
    end else begin
      rise_pulse_r <= edge_ok_s & ~in_data_r &  in_data_s;
      fall_pulse_r <= edge_ok_s &  in_data_r & ~in_data_s;
    end
  end

  // Sticky interrupt; a new event beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_r <= 1'b0;
    end else if ((rise_pulse_r & rise_en) | (fall_pulse_r & fall_en)) begin
      irq_r <= 1'b1;
    end else if (irq_clr) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  assign pad_a      = pad_a_r;
  assign pad_dir    = pad_dir_r;
  assign in_data    = in_data_r;
  assign rise_pulse = rise_pulse_r;
  assign fall_pulse = fall_pulse_r;
  assign irq        = irq_r;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed self-checking bench for gpio_pad_ctrl (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expectations follow the build: GPIO_PAD_DEBOUNCE_EN defined or not.
module tb_gpio_pad_ctrl;

`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int LAT   = 6;
  localparam int BLANK = 6;
  localparam bit DBNC  = 1'b1;
`else
  localparam int LAT   = 3;
  localparam int BLANK = 2;
  localparam bit DBNC  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, out_data, dir, rise_en, fall_en, irq_clr, pad_y;
  logic pad_a, pad_dir, in_data, rise_pulse, fall_pulse, irq;
  logic exp_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .out_data   (out_data),
    .dir        (dir),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .irq_clr    (irq_clr),
    .pad_a      (pad_a),
    .pad_dir    (pad_dir),
    .pad_y      (pad_y),
    .in_data    (in_data),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .irq        (irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; out_data = 1'b0; dir = 1'b1; rise_en = 1'b0;
    fall_en = 1'b0; irq_clr = 1'b0; pad_y = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pad_dir !== 1'b1) begin errors++; $display("FAIL reset_pad_dir: got %b expected 1", pad_dir); end
    checks++; if (pad_a !== 1'b0) begin errors++; $display("FAIL reset_pad_a: got %b expected 0", pad_a); end
    checks++; if (in_data !== 1'b0) begin errors++; $display("FAIL reset_in_data: got %b expected 0", in_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (rise_pulse !== 1'b0) begin errors++; $display("FAIL reset_rise: got %b expected 0", rise_pulse); end
    checks++; if (fall_pulse !== 1'b0) begin errors++; $display("FAIL reset_fall: got %b expected 0", fall_pulse); end
  endtask

  task automatic test_output_path();
    do_reset();
    dir = 1'b0; out_data = 1'b1;
    #1;
    checks++; if (pad_a !== 1'b0) begin errors++; $display("FAIL out_before_edge: got %b expected 0", pad_a); end
    step();
    checks++; if (pad_dir !== 1'b0) begin errors++; $display("FAIL out_pad_dir: got %b expected 0", pad_dir); end
    checks++; if (pad_a !== 1'b1) begin errors++; $display("FAIL out_pad_a: got %b expected 1", pad_a); end
    out_data = 1'b0;
    step();
    checks++; if (pad_a !== 1'b0) begin errors++; $display("FAIL out_pad_a_low: got %b expected 0", pad_a); end
  endtask

  task automatic test_debounced_rise();
    do_reset();
    rise_en = 1'b1; pad_y = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      exp_b = (k == LAT);
      checks++; if (in_data !== exp_b) begin errors++; $display("FAIL rise_in_data edge %0d: got %b expected %b", k, in_data, exp_b); end
      checks++; if (rise_pulse !== exp_b) begin errors++; $display("FAIL rise_pulse edge %0d: got %b expected %b", k, rise_pulse, exp_b); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early edge %0d: got %b expected 0", k, irq); end
    end
    step();
    checks++; if (rise_pulse !== 1'b0) begin errors++; $display("FAIL rise_pulse_width: got %b expected 0", rise_pulse); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq_set: got %b expected 1", irq); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_clr: got %b expected 0", irq); end
  endtask

  task automatic test_irq_collision();
    do_reset();
    pad_y = 1'b1;
    repeat (LAT + 1) step();
    fall_en = 1'b1; pad_y = 1'b0;
    repeat (LAT) step();
    checks++; if (fall_pulse !== 1'b1) begin errors++; $display("FAIL coll_fall_pulse: got %b expected 1", fall_pulse); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_irq_pre: got %b expected 0", irq); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_set_wins: got %b expected 1", irq); end
    checks++; if (fall_pulse !== 1'b0) begin errors++; $display("FAIL coll_fall_width: got %b expected 0", fall_pulse); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b expected 0", irq); end
  endtask

  task automatic test_glitch();
    logic exp_in, exp_r, exp_f;
    do_reset();
    rise_en = 1'b1;
    pad_y = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 3) pad_y = 1'b0;
      exp_in = !DBNC && (k >= 3) && (k <= 5);
      exp_r  = !DBNC && (k == 3);
      exp_f  = !DBNC && (k == 6);
      checks++; if (in_data !== exp_in) begin errors++; $display("FAIL glitch_in_data edge %0d: got %b expected %b", k, in_data, exp_in); end
      checks++; if (rise_pulse !== exp_r) begin errors++; $display("FAIL glitch_rise edge %0d: got %b expected %b", k, rise_pulse, exp_r); end
      checks++; if (fall_pulse !== exp_f) begin errors++; $display("FAIL glitch_fall edge %0d: got %b expected %b", k, fall_pulse, exp_f); end
    end
    exp_b = !DBNC;
    checks++; if (irq !== exp_b) begin errors++; $display("FAIL glitch_irq: got %b expected %b", irq, exp_b); end
  endtask

  task automatic test_turnaround();
    do_reset();
    rise_en = 1'b1; fall_en = 1'b1;
    // dir drops while the rise is being qualified; the count must survive
    pad_y = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 4) dir = 1'b0;
      exp_b = (j == LAT) && (j <= 5);
      checks++; if (rise_pulse !== exp_b) begin errors++; $display("FAIL turn_a_rise edge %0d: got %b expected %b", j, rise_pulse, exp_b); end
      if (j == LAT) begin
        checks++; if (in_data !== 1'b1) begin errors++; $display("FAIL turn_a_in_data: got %b expected 1", in_data); end
      end
    end
    checks++; if (pad_dir !== 1'b0) begin errors++; $display("FAIL turn_a_pad_dir: got %b expected 0", pad_dir); end
    exp_b = !DBNC;
    checks++; if (irq !== exp_b) begin errors++; $display("FAIL turn_a_irq: got %b expected %b", irq, exp_b); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    // output mode: pad toggles, in_data follows, no strobes
    pad_y = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      checks++; if (fall_pulse !== 1'b0) begin errors++; $display("FAIL turn_b_fall edge %0d: got %b expected 0", j, fall_pulse); end
    end
    checks++; if (in_data !== 1'b0) begin errors++; $display("FAIL turn_b_in_data: got %b expected 0", in_data); end
    // back to input: toggle inside the blanking window
    dir = 1'b1;
    step();
    checks++; if (pad_dir !== 1'b1) begin errors++; $display("FAIL turn_c_pad_dir: got %b expected 1", pad_dir); end
    pad_y = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      exp_b = (j == LAT) && (j > BLANK);
      checks++; if (rise_pulse !== exp_b) begin errors++; $display("FAIL turn_c_rise edge %0d: got %b expected %b", j, rise_pulse, exp_b); end
      if (j == LAT) begin
        checks++; if (in_data !== 1'b1) begin errors++; $display("FAIL turn_c_in_data: got %b expected 1", in_data); end
      end
    end
    exp_b = !DBNC;
    checks++; if (irq !== exp_b) begin errors++; $display("FAIL turn_c_irq: got %b expected %b", irq, exp_b); end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    rise_en = 1'b1;
    pad_y = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    checks++; if (in_data !== 1'b0) begin errors++; $display("FAIL midrst_in_data: got %b expected 0", in_data); end
    checks++; if (rise_pulse !== 1'b0) begin errors++; $display("FAIL midrst_rise: got %b expected 0", rise_pulse); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b expected 0", irq); end
    rst = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      exp_b = (k == LAT);
      checks++; if (in_data !== exp_b) begin errors++; $display("FAIL midrst_restart edge %0d: got %b expected %b", k, in_data, exp_b); end
      checks++; if (rise_pulse !== exp_b) begin errors++; $display("FAIL midrst_rise edge %0d: got %b expected %b", k, rise_pulse, exp_b); end
    end
  endtask

  initial begin
    test_reset();
    test_output_path();
    test_debounced_rise();
    test_irq_collision();
    test_glitch();
    test_turnaround();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
